// File: rtl/wb_daq_sample_writer_if.sv
// Wishbone classic master/slave bundle used by the DAQ sample writer.
interface wb_daq_sample_writer_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wb_daq_sample_writer.sv
// Packs pairs of 16-bit ADC samples into 32-bit words and writes them to RAM over Wishbone.
// A small word buffer absorbs bus latency; rty re-issues the same beat, err aborts the run.
module wb_daq_sample_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_STEP  = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        bus_error,
  wb_daq_sample_writer_if.master wb_master
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
  localparam logic [31:0] STEP     = 32'(ADDR_STEP);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, RETRY, FINISH} state_t;
  state_t state, state_nxt;

  logic [31:0] base_q;
  logic [15:0] count_q, packed_q, acked_q;
  logic        half_q;
  logic [15:0] lo_q;
  logic        push_q;
  logic [31:0] word_q;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;

  logic start_ok, accepting, take, full, pop, push_ok, avail, flush;
  logic unused_dat;

  assign start_ok   = start && !busy;
  assign accepting  = busy && (packed_q < count_q);
  assign take       = sample_valid && accepting;
  assign full       = (level == FULL_LVL);
  assign pop        = (state == FETCH);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_ok    = push_q && (!full || pop);
  // Counting the in-flight push lets the writer leave IDLE one cycle earlier.
  assign avail      = (level != '0) || push_q;
  assign flush      = (state == WRITE) && wb_master.err_i;
  assign unused_dat = ^wb_master.dat_i;

  assign done            = (state == FINISH);
  assign wb_master.cyc_o = (state == WRITE);
  assign wb_master.stb_o = (state == WRITE);
  assign wb_master.we_o  = (state == WRITE);
  assign wb_master.sel_o = {4{state == WRITE}};
  assign wb_master.cti_o = 3'b000;
  assign wb_master.bte_o = 2'b00;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (busy) begin
          if (acked_q == count_q) state_nxt = FINISH;
          else if (avail)         state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = WRITE;
      WRITE: begin
        if (wb_master.err_i) begin
          state_nxt = FINISH;
        end else if (wb_master.ack_i) begin
          if ((acked_q + 16'd1) == count_q) state_nxt = FINISH;
          else if (avail)                   state_nxt = FETCH;
          else                              state_nxt = IDLE;
        end else if (wb_master.rty_i) begin
          state_nxt = RETRY;
        end
      end
      RETRY:   state_nxt = WRITE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem[wr_ptr] <= word_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state           <= IDLE;
      base_q          <= '0;
      count_q         <= '0;
      packed_q        <= '0;
      acked_q         <= '0;
      half_q          <= 1'b0;
      lo_q            <= '0;
      push_q          <= 1'b0;
      word_q          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
      bus_error       <= 1'b0;
      wb_master.adr_o <= '0;
      wb_master.dat_o <= '0;
    end else begin
      state  <= state_nxt;
      push_q <= take && half_q;
      if (take) begin
        if (half_q) word_q <= {sample_data, lo_q};
        else        lo_q   <= sample_data;
        half_q <= !half_q;
      end

      if (flush || start_ok) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      level <= level + ONE_LVL;
        else if (!push_ok && pop) level <= level - ONE_LVL;
      end

      if (push_ok && !flush) packed_q <= packed_q + 16'd1;
      if (push_q && !push_ok) overflow <= 1'b1;

      if (pop) begin
        wb_master.dat_o <= mem[rd_ptr];
        wb_master.adr_o <= base_q + 32'(acked_q) * STEP;
      end

      if ((state == WRITE) && wb_master.ack_i && !wb_master.err_i)
        acked_q <= acked_q + 16'd1;
      if (flush) bus_error <= 1'b1;
      if (state_nxt == FINISH) busy <= 1'b0;

      if (start_ok) begin
        base_q    <= base_addr;
        count_q   <= word_count;
        packed_q  <= '0;
        acked_q   <= '0;
        half_q    <= 1'b0;
        push_q    <= 1'b0;
        overflow  <= 1'b0;
        bus_error <= 1'b0;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: doc/wb_daq_sample_writer.md
WB_DAQ_SAMPLE_WRITER -- requirements
Module: wb_daq_sample_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, packed-word buffer depth (power of 2, min 2).
REQ-002 Parameter ADDR_STEP, default 4, byte increment between successive words.
REQ-003 wb_clk  input  1  sole clock; all logic on rising edge.
REQ-004 wb_rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that arms a capture run.
REQ-006 base_addr  input  32  RAM byte address of first word, sampled on start.
REQ-007 word_count  input  16  number of 32-bit words per run, sampled on start.
REQ-008 sample_valid  input  1  ADC sample strobe, already in wb_clk domain.
REQ-009 sample_data  input  16  ADC sample, qualified by sample_valid.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 overflow  output  1  sticky, a packed word was dropped due to full buffer.
REQ-013 bus_error  output  1  sticky, a write terminated with err.
REQ-014 wb_master_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  output  32/32/4/1/1/1/3/2  Wishbone master.
REQ-015 wb_master_dat_i/ack_i/err_i/rty_i  input  32/1/1/1  Wishbone master responses; dat_i ignored.

Function
REQ-016 start while busy=0 SHALL latch base_addr and word_count, clear overflow, bus_error and pack/word counters, set busy next cycle; start while busy=1 SHALL be ignored.
REQ-017 sample_valid while not accepting SHALL be discarded; accepting = busy and packed-word count < word_count.
REQ-018 Packing: first accepted sample to dat[15:0], second to dat[31:16]; word pushed to buffer on the cycle after the second sample.
REQ-019 Push into full buffer SHALL drop the word, set overflow, not advance packed-word count.
REQ-020 Simultaneous push and pop on full buffer SHALL succeed without overflow.
REQ-021 Writer FSM states: IDLE, FETCH, WRITE, RETRY, FINISH.
REQ-022 IDLE -> FETCH when busy and buffer non-empty; FETCH pops one word into dat_o register, drives adr_o = base + n*ADDR_STEP (n = words acked), -> WRITE.
REQ-023 WRITE: cyc_o=stb_o=we_o=1, sel_o=4'hF, cti_o=3'b000, bte_o=2'b00; hold all bus outputs stable until ack, err or rty.
REQ-024 ack -> increment n; n==word_count -> FINISH, else buffer non-empty -> FETCH, else IDLE.
REQ-025 rty -> RETRY: cyc_o/stb_o low one cycle, then WRITE re-issues identical address/data.
REQ-026 err -> set bus_error, flush buffer, stop accepting samples, -> FINISH.
REQ-027 FINISH: done=1 for exactly one cycle, busy cleared same cycle, -> IDLE.
REQ-028 word_count=0: no bus cycle; done pulses second cycle after start.
REQ-029 Latency: word pushed in cycle N with bus idle -> cyc_o/stb_o high in cycle N+2.
REQ-030 Address arithmetic 32-bit, wraps modulo 2^32.
REQ-031 cyc_o/stb_o SHALL be low in IDLE, FETCH, RETRY, FINISH.
REQ-032 Overflowed words never issued; run still completes after word_count words acked.

Reset
REQ-033 wb_rst SHALL force IDLE, empty buffer, clear pack half-word, counters, busy, done, overflow, bus_error, cyc_o, stb_o, we_o; adr_o, dat_o = 0; sel_o = 0; cti_o = 0; bte_o = 0.
REQ-034 wb_rst mid-transaction SHALL drop cyc_o/stb_o on the following edge; no done pulse.
REQ-035 A start in the reset cycle SHALL be ignored.

Verification
REQ-036 base=0x100, count=2, samples 0x1111,0x2222,0x3333,0x4444, zero-wait ack -> writes 0x22221111@0x100, 0x44443333@0x104, one done, overflow=0.
REQ-037 count=4, ack held off 20 cycles, samples every cycle, FIFO_DEPTH=2 -> overflow=1, four writes still complete, done pulses once.
REQ-038 rty on first write of base=0x200 -> cyc low one cycle, re-issue same adr/dat, then ack; done.
REQ-039 err on second write, count=3 -> bus_error=1, no third write, done pulses, busy=0.
REQ-040 count=0 start -> done two cycles later, cyc_o never asserted; second start during busy run ignored.
REQ-041 wb_rst asserted while stb_o=1 -> all outputs at reset values next cycle, no done.
